// File: rtl/mem_fill_if.sv
// Host-side bus of mem_fill: read/write port, range-bound loads, fill control and status.
interface mem_fill_if #(
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 8
);
  logic                 ld_low;
  logic                 ld_high;
  logic [ADDRWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0] din;
  logic                 write;
  logic                 fill;
  logic                 mode;
  logic                 abort;
  logic [DATAWIDTH-1:0] dout;
  logic                 busy;
  logic                 done;

  modport master (
    output ld_low, ld_high, addr, din, write, fill, mode, abort,
    input  dout, busy, done
  );

  modport slave (
    input  ld_low, ld_high, addr, din, write, fill, mode, abort,
    output dout, busy, done
  );
endinterface

// File: rtl/mem_fill.sv
// Scratch RAM with a hardware range-fill engine: constant or incrementing pattern
// over a wrapping [lo, hi] address range, with abort and a completion pulse.
module mem_fill #(
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 8
) (
  input logic      clock,
  input logic      reset,
  mem_fill_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  typedef enum logic {IDLE, FILL} state_t;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] lo_q, lo_d;
  logic [ADDRWIDTH-1:0] hi_q, hi_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] val_q, val_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] dout_q;

  logic                 we;
  logic [ADDRWIDTH-1:0] waddr;
  logic [DATAWIDTH-1:0] wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = bus.addr;
    wdata   = bus.din;

    unique case (state_q)
      IDLE: begin
        // A fill strobe shadows any host write or bound load in the same cycle.
        if (bus.fill) begin
          cnt_d   = lo_q;
          val_d   = bus.din;
          mode_d  = bus.mode;
          state_d = FILL;
        end else begin
          we = bus.write;
          if (bus.ld_low)  lo_d = bus.addr;
          if (bus.ld_high) hi_d = bus.addr;
        end
      end
      FILL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          we    = 1'b1;
          waddr = cnt_q;
          wdata = val_q;
          if (cnt_q == hi_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDRWIDTH'(1);
            val_d = val_q + DATAWIDTH'(mode_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port is only live in IDLE, so dout holds its last value during a fill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else if (state_q == IDLE) begin
      dout_q <= mem[bus.addr];
    end
  end

  assign bus.busy = (state_q == FILL);
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_mem_fill.sv
// Self-checking bench for mem_fill: table of fill vectors, a reference memory model
// and a read scoreboard, plus hand-written host, back-to-back and reset sequences.
module tb_mem_fill;

  logic clock;
  logic reset;

  mem_fill_if #(.ADDRWIDTH(6), .DATAWIDTH(8)) bus ();

  mem_fill #(.ADDRWIDTH(6), .DATAWIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [5:0] lo;
    logic [5:0] hi;
    logic [7:0] seed;
    logic       mode;
    int         abort_at;
    int         exp_busy;
    int         exp_done;
  } fill_vec_t;

  typedef struct {
    int         a;
    logic [7:0] exp;
    int         due;
  } rd_t;

  logic [7:0] model [64];
  rd_t        sb [$];
  rd_t        ent;
  fill_vec_t  vecs [7];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Read results are compared on the falling edge after the capturing clock edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      if (ent.due != cyc) check("sb_late", 32'(ent.due), 32'(cyc));
      check($sformatf("rd[%0d]", ent.a), 32'(bus.dout), 32'(ent.exp));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    bus.addr  = 6'(a);
    bus.din   = d;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    model[a]  = d;
  endtask

  task automatic host_read(input int a);
    rd_t r;
    bus.addr  = 6'(a);
    bus.write = 1'b0;
    r.a   = a;
    r.exp = model[a];
    r.due = cyc + 1;
    sb.push_back(r);
    tick();
  endtask

  task automatic read_all();
    for (int i = 0; i < 64; i++) host_read(i);
  endtask

  task automatic run_fill(input fill_vec_t v, input bit do_load);
    int         n, wr, bcnt, dcnt, guard;
    logic [5:0] side;
    logic [7:0] dexp;
    n = ((int'(v.hi) - int'(v.lo)) & 63) + 1;
    if (do_load) begin
      if (v.lo == v.hi) begin
        bus.addr = v.lo; bus.ld_low = 1'b1; bus.ld_high = 1'b1;
        tick();
        bus.ld_low = 1'b0; bus.ld_high = 1'b0;
      end else begin
        bus.addr = v.lo; bus.ld_low = 1'b1;
        tick();
        bus.ld_low = 1'b0;
        bus.addr = v.hi; bus.ld_high = 1'b1;
        tick();
        bus.ld_high = 1'b0;
      end
    end
    side = v.hi + 6'd1;
    dexp = model[side];
    // Host write asserted with the strobe and throughout the fill must be ignored.
    bus.addr  = side;
    bus.din   = v.seed;
    bus.mode  = v.mode;
    bus.fill  = 1'b1;
    bus.write = 1'b1;
    tick();
    bus.fill = 1'b0;
    bus.din  = ~v.seed;
    check("busy_start", 32'(bus.busy), 32'd1);
    bcnt = 0; dcnt = 0; guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      bcnt++;
      guard++;
      if (bcnt == v.abort_at) bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      if (bus.done === 1'b1) dcnt++;
    end
    bus.write = 1'b0;
    check("busy_cycles", 32'(bcnt), 32'(v.exp_busy));
    check("done_pulses", 32'(dcnt), 32'(v.exp_done));
    check("dout_hold", 32'(bus.dout), 32'(dexp));
    tick();
    check("done_fall", 32'(bus.done), 32'd0);
    wr = (v.abort_at > 0) ? v.abort_at - 1 : n;
    for (int k = 0; k < wr; k++)
      model[(int'(v.lo) + k) & 63] = v.mode ? 8'(int'(v.seed) + k) : v.seed;
  endtask

  initial begin
    int         guard;
    logic [7:0] d0;
    fill_vec_t  rv;

    //            lo     hi     seed   mode  abort busy done
    vecs[0] = '{6'd4,  6'd7,  8'h10, 1'b1, 0, 4,  1};
    vecs[1] = '{6'd0,  6'd2,  8'hFE, 1'b1, 0, 3,  1};
    vecs[2] = '{6'd62, 6'd1,  8'hFF, 1'b0, 0, 4,  1};
    vecs[3] = '{6'd5,  6'd5,  8'h3C, 1'b0, 0, 1,  1};
    vecs[4] = '{6'd0,  6'd63, 8'h80, 1'b1, 0, 64, 1};
    vecs[5] = '{6'd10, 6'd9,  8'h21, 1'b0, 0, 64, 1};
    vecs[6] = '{6'd0,  6'd9,  8'h55, 1'b0, 3, 3,  0};

    bus.ld_low = 1'b0; bus.ld_high = 1'b0; bus.addr = '0; bus.din = '0;
    bus.write = 1'b0; bus.fill = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #20;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    #5 reset = 1'b1;
    tick();

    for (int i = 0; i < 64; i++) host_write(i, 8'((i * 7 + 3) & 255));
    read_all();

    // Host path: write then read, then same-cycle write/read returns the old word.
    host_write(3, 8'hA5);
    host_read(3);
    bus.addr = 6'd3; bus.din = 8'h5A; bus.write = 1'b1;
    ent.a = 3; ent.exp = model[3]; ent.due = cyc + 1;
    sb.push_back(ent);
    tick();
    bus.write = 1'b0;
    model[3] = 8'h5A;
    host_read(3);

    for (int i = 0; i < 7; i++) begin
      run_fill(vecs[i], 1'b1);
      read_all();
    end

    // Back-to-back: second strobe in the cycle done is high.
    rv = '{6'd20, 6'd21, 8'h40, 1'b1, 0, 2, 1};
    run_fill(rv, 1'b1);
    bus.addr = 6'd20; bus.ld_low = 1'b1; tick(); bus.ld_low = 1'b0;
    bus.addr = 6'd22; bus.ld_high = 1'b1; tick(); bus.ld_high = 1'b0;
    bus.din = 8'h90; bus.mode = 1'b0; bus.fill = 1'b1;
    tick();
    bus.fill = 1'b0; bus.din = 8'h40; bus.mode = 1'b1; bus.fill = 1'b1;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
      if (bus.busy === 1'b1 && bus.done !== 1'b1) bus.fill = 1'b0;
    end
    check("b2b_first_done", 32'(bus.done), 32'd1);
    bus.addr = 6'd20; bus.din = 8'hC0; bus.mode = 1'b1; bus.fill = 1'b1;
    tick();
    bus.fill = 1'b0;
    check("b2b_accept", 32'(bus.busy), 32'd1);
    guard = 0;
    while (bus.busy === 1'b1 && guard < 20) begin tick(); guard++; end
    check("b2b_second_len", 32'(guard), 32'd3);
    for (int k = 0; k < 3; k++) model[20 + k] = 8'h90;
    for (int k = 0; k < 3; k++) model[20 + k] = 8'(8'hC0 + k);
    tick();
    read_all();

    // Reset in the second busy cycle: outputs clear without a clock edge.
    host_write(40, 8'hE7);
    bus.addr = 6'd0; bus.ld_low = 1'b1; tick(); bus.ld_low = 1'b0;
    bus.addr = 6'd9; bus.ld_high = 1'b1; tick(); bus.ld_high = 1'b0;
    host_read(40);
    bus.din = 8'h66; bus.mode = 1'b0; bus.fill = 1'b1;
    tick();
    bus.fill = 1'b0;
    tick();
    check("pre_rst_dout", 32'(bus.dout), 32'hE7);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    check("async_dout", 32'(bus.dout), 32'd0);
    model[0] = 8'h66;
    #10 reset = 1'b1;
    tick();
    rv = '{6'd0, 6'd0, 8'h77, 1'b0, 0, 1, 1};
    run_fill(rv, 1'b0);
    read_all();

    tick();
    tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_fill.md
# mem_fill

Parametrised memory with a hardware range-fill engine. It is the successor to the zero-on-command memory block, generalised in three ways: any address range (with wrap-around), a programmable fill pattern, and an incrementing-pattern mode. It also adds abort and a completion pulse. It sits beside the host bus as a small scratch/lookup RAM that firmware can bulk-initialise without issuing per-word writes.

## Interface
- ADDRWIDTH, 6, address width; memory depth is 2^ADDRWIDTH words.
- DATAWIDTH, 8, word width.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_low  in  1  load range start register from addr.
- ld_high  in  1  load range end register from addr.
- addr  in  ADDRWIDTH  host read/write address; also the bound source for ld_low/ld_high.
- din  in  DATAWIDTH  host write data; fill seed when fill is sampled.
- write  in  1  host write strobe.
- fill  in  1  start range fill (single-cycle strobe).
- mode  in  1  0 = constant fill, 1 = incrementing fill; sampled with fill.
- abort  in  1  terminate an active fill.
- dout  out  DATAWIDTH  registered read data.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse on normal fill completion.

## Operation
- Storage: 2^ADDRWIDTH x DATAWIDTH array. Contents are not reset.
- Internal registers: lo_reg, hi_reg (ADDRWIDTH), cnt (ADDRWIDTH), val (DATAWIDTH), mode_r.
- FSM states: IDLE and FILL.
- IDLE, priority fill > write/ld.
  - fill=1: latch cnt<=lo_reg, val<=din, mode_r<=mode, then go to FILL with busy<=1. Any write, ld_low or ld_high in the same cycle is ignored.
  - Otherwise: write=1 gives mem[addr]<=din. ld_low gives lo_reg<=addr. ld_high gives hi_reg<=addr. These may occur together in one cycle.
  - Every cycle: dout<=mem[addr] (read-before-write when write targets the same addr).
- FILL, each cycle:
  - abort=1: no write. Go to IDLE, busy<=0, done stays 0.
  - Else: mem[cnt]<=val. If cnt==hi_reg, go to IDLE with busy<=0 and done<=1. Otherwise cnt<=cnt+1 (mod 2^ADDRWIDTH) and val<=val+mode_r (mod 2^DATAWIDTH).
  - write, fill, ld_low and ld_high are ignored. dout holds its last value.
- Range arithmetic:
  - Word count N = ((hi_reg - lo_reg) mod 2^ADDRWIDTH) + 1.
  - lo_reg > hi_reg wraps through address 2^ADDRWIDTH-1 to 0.
  - lo_reg == hi_reg fills exactly one word.
  - A full-memory fill is lo_reg = hi_reg+1 (mod depth).
- Pattern: the k-th word written (k = 0..N-1) equals seed when mode=0, and (seed + k) mod 2^DATAWIDTH when mode=1. The value wraps silently.
- abort while IDLE has no effect.

## Timing
- Reset (asynchronous, reset=0):
  - busy=0, done=0, dout=0, lo_reg=0, hi_reg=0, cnt=0, val=0, mode_r=0, state=IDLE.
  - A fill in progress stops immediately. Words already written keep their values.
- Host read latency: 1 cycle (addr at edge t gives dout valid after edge t).
- Host write takes effect at the sampling edge.
- Fill sampled at edge t0:
  - busy=1 from t0 through t0+N.
  - Word k is written at edge t0+1+k.
  - busy falls and done rises at edge t0+N. done falls at t0+N+1.
  - busy is high for exactly N cycles.
- A new fill is accepted in the cycle done is high, so back-to-back fills lose no cycles.
- abort sampled at edge ta: busy=0 after ta. Words written are exactly those at edges before ta.

## Test plan
- Host path: write din=0xA5 at addr=3, then present addr=3 → dout=0xA5 one cycle later. Also write and read addr 3 in the same cycle → dout shows the old value.
- Incrementing fill: lo=4, hi=7, din=0x10, mode=1, fill → busy high 4 cycles, single done pulse, mem[4..7]=0x10,0x11,0x12,0x13, mem[3] and mem[8] unchanged. Data wrap check: seed 0xFE, lo=0, hi=2 → 0xFE,0xFF,0x00.
- Wrap-around range: lo=62, hi=1, din=0xFF, mode=0 → busy 4 cycles, mem[62],mem[63],mem[0],mem[1]=0xFF, mem[2] unchanged.
- Degenerate and full ranges: lo=hi=5 → busy 1 cycle, only mem[5] written. lo=0, hi=63 → busy 64 cycles, every word written.
- Abort: lo=0, hi=9, mode=0, din=0x55. Assert abort on the third busy cycle → mem[0..1]=0x55, mem[2..9] unchanged, done never asserted, busy low next cycle. A host write issued while busy is ignored.
- Reset mid-fill: drop reset during the 2nd busy cycle → busy, done and dout go to 0 immediately without a clock edge. After release, a fresh fill runs normally from lo=hi=0 (1 word).
